// File: rtl/gemm_loop_ctrl.sv
// GEMM loop sequencer: walks the two-level loop nest over a micro-op range,
// emits upc to the micro-op store, and turns each returned micro-op into
// accumulator/input/weight indices plus a delayed accumulator write-back.
// The micro-op store's read pipeline must hold its output while stall is high.
module gemm_loop_ctrl #(
  parameter int unsigned UPC_WIDTH     = 13,
  parameter int unsigned ITER_WIDTH    = 14,
  parameter int unsigned ACC_IDX_WIDTH = 11,
  parameter int unsigned INP_IDX_WIDTH = 11,
  parameter int unsigned WGT_IDX_WIDTH = 10,
  parameter int unsigned UOP_LAT       = 1,
  parameter int unsigned WB_LAT        = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [127:0]             insn,
  input  logic                     insn_valid,
  output logic                     insn_ready,
  input  logic                     stall,
  output logic [UPC_WIDTH-1:0]     upc,
  input  logic [31:0]              uop_data,
  output logic                     idx_valid,
  output logic [ACC_IDX_WIDTH-1:0] acc_rd_idx,
  output logic [INP_IDX_WIDTH-1:0] inp_idx,
  output logic [WGT_IDX_WIDTH-1:0] wgt_idx,
  output logic                     reset_mode,
  output logic                     acc_wr_en,
  output logic [ACC_IDX_WIDTH-1:0] acc_wr_idx,
  output logic                     done
);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;
  state_e state_q, state_d;

  // Instruction field decode
  logic [UPC_WIDTH-1:0]     f_bgn;
  logic [UPC_WIDTH:0]       f_end;
  logic [ITER_WIDTH-1:0]    f_iter_out, f_iter_in;
  logic [ACC_IDX_WIDTH-1:0] f_dst_out, f_dst_in;
  logic [INP_IDX_WIDTH-1:0] f_src_out, f_src_in;
  logic [WGT_IDX_WIDTH-1:0] f_wgt_out, f_wgt_in;
  logic                     f_empty;
  wire                      unused_insn;

  assign f_bgn       = UPC_WIDTH'(insn[20:8]);
  assign f_end       = (UPC_WIDTH + 1)'(insn[34:21]);
  assign f_iter_out  = ITER_WIDTH'(insn[48:35]);
  assign f_iter_in   = ITER_WIDTH'(insn[62:49]);
  assign f_dst_out   = ACC_IDX_WIDTH'(insn[73:63]);
  assign f_dst_in    = ACC_IDX_WIDTH'(insn[84:74]);
  assign f_src_out   = INP_IDX_WIDTH'(insn[95:85]);
  assign f_src_in    = INP_IDX_WIDTH'(insn[106:96]);
  assign f_wgt_out   = WGT_IDX_WIDTH'(insn[116:107]);
  assign f_wgt_in    = WGT_IDX_WIDTH'(insn[126:117]);
  assign f_empty     = (f_iter_out == '0) || (f_iter_in == '0) || (f_end <= {1'b0, f_bgn});
  assign unused_insn = ^{insn[127], insn[6:0]};

  // Latched instruction and loop state
  logic [UPC_WIDTH:0]       end_q;
  logic [UPC_WIDTH-1:0]     bgn_q;
  logic [ITER_WIDTH-1:0]    iter_out_q, iter_in_q, i_q, j_q;
  logic [ACC_IDX_WIDTH-1:0] dst_out_q, dst_in_q, acc_out_off_q, acc_in_off_q;
  logic [INP_IDX_WIDTH-1:0] src_out_q, src_in_q, inp_out_off_q, inp_in_off_q;
  logic [WGT_IDX_WIDTH-1:0] wgt_out_q, wgt_in_q, wgt_out_off_q, wgt_in_off_q;

  logic accept, issue, upc_last, i_last, j_last, last_issue, busy;

  // Pipeline from issue to index output, then write-back delay line
  logic [UOP_LAT-1:0]       pipe_vld_q;
  logic [ACC_IDX_WIDTH-1:0] acc_off_q [UOP_LAT];
  logic [INP_IDX_WIDTH-1:0] inp_off_q [UOP_LAT];
  logic [WGT_IDX_WIDTH-1:0] wgt_off_q [UOP_LAT];
  logic                     idx_vld_q;
  logic [WB_LAT-1:0]        wb_vld_q;
  logic [ACC_IDX_WIDTH-1:0] wb_idx_q [WB_LAT];

  assign accept     = insn_valid && (state_q == StIdle);
  assign issue      = (state_q == StIssue) && !stall;
  assign upc_last   = ({1'b0, upc} == end_q - (UPC_WIDTH + 1)'(1));
  assign i_last     = (i_q == iter_out_q - ITER_WIDTH'(1));
  assign j_last     = (j_q == iter_in_q - ITER_WIDTH'(1));
  assign last_issue = issue && upc_last && i_last && j_last;

  // Work in flight that still needs at least one more cycle; the final
  // write-back stage completes in the current cycle when not stalled.
  always_comb begin
    busy = (|pipe_vld_q) | idx_vld_q;
    for (int k = 0; k < int'(WB_LAT) - 1; k++) begin
      busy = busy | wb_vld_q[k];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = f_empty ? StDone : StIssue;
      StIssue: if (last_issue) state_d = StDrain;
      StDrain: if (!stall && !busy) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake and stall-masked beat outputs
  always_comb begin
    insn_ready = (state_q == StIdle);
    done       = (state_q == StDone);
    idx_valid  = idx_vld_q & ~stall;
    acc_wr_en  = wb_vld_q[WB_LAT-1] & ~stall;
    acc_wr_idx = wb_idx_q[WB_LAT-1];
  end

  // Loop counters and running offsets (i*stride_out, j*stride_in by addition)
  always_ff @(posedge clk) begin
    if (rst) begin
      upc <= '0;  bgn_q <= '0;  end_q <= '0;
      iter_out_q <= '0;  iter_in_q <= '0;  i_q <= '0;  j_q <= '0;
      dst_out_q <= '0;  dst_in_q <= '0;  src_out_q <= '0;  src_in_q <= '0;
      wgt_out_q <= '0;  wgt_in_q <= '0;
      acc_out_off_q <= '0;  acc_in_off_q <= '0;
      inp_out_off_q <= '0;  inp_in_off_q <= '0;
      wgt_out_off_q <= '0;  wgt_in_off_q <= '0;
      reset_mode <= 1'b0;
    end else if (accept) begin
      bgn_q <= f_bgn;  end_q <= f_end;
      iter_out_q <= f_iter_out;  iter_in_q <= f_iter_in;
      dst_out_q <= f_dst_out;  dst_in_q <= f_dst_in;
      src_out_q <= f_src_out;  src_in_q <= f_src_in;
      wgt_out_q <= f_wgt_out;  wgt_in_q <= f_wgt_in;
      reset_mode <= insn[7];
      i_q <= '0;  j_q <= '0;
      acc_out_off_q <= '0;  acc_in_off_q <= '0;
      inp_out_off_q <= '0;  inp_in_off_q <= '0;
      wgt_out_off_q <= '0;  wgt_in_off_q <= '0;
      if (!f_empty) upc <= f_bgn;
    end else if (issue && !last_issue) begin
      // On the very last issue everything holds so upc keeps its final value
      if (upc_last) begin
        upc <= bgn_q;
        if (j_last) begin
          j_q <= '0;
          i_q <= i_q + ITER_WIDTH'(1);
          acc_in_off_q  <= '0;
          inp_in_off_q  <= '0;
          wgt_in_off_q  <= '0;
          acc_out_off_q <= acc_out_off_q + dst_out_q;
          inp_out_off_q <= inp_out_off_q + src_out_q;
          wgt_out_off_q <= wgt_out_off_q + wgt_out_q;
        end else begin
          j_q <= j_q + ITER_WIDTH'(1);
          acc_in_off_q <= acc_in_off_q + dst_in_q;
          inp_in_off_q <= inp_in_off_q + src_in_q;
          wgt_in_off_q <= wgt_in_off_q + wgt_in_q;
        end
      end else begin
        upc <= upc + UPC_WIDTH'(1);
      end
    end
  end

  // Index pipeline: offsets ride alongside the micro-op read, whole pipe frozen on stall
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld_q <= '0;
      for (int k = 0; k < int'(UOP_LAT); k++) begin
        acc_off_q[k] <= '0;
        inp_off_q[k] <= '0;
        wgt_off_q[k] <= '0;
      end
      idx_vld_q  <= 1'b0;
      acc_rd_idx <= '0;
      inp_idx    <= '0;
      wgt_idx    <= '0;
      wb_vld_q   <= '0;
      for (int k = 0; k < int'(WB_LAT); k++) wb_idx_q[k] <= '0;
    end else if (!stall) begin
      pipe_vld_q[0] <= issue;
      acc_off_q[0]  <= acc_out_off_q + acc_in_off_q;
      inp_off_q[0]  <= inp_out_off_q + inp_in_off_q;
      wgt_off_q[0]  <= wgt_out_off_q + wgt_in_off_q;
      for (int k = 1; k < int'(UOP_LAT); k++) begin
        pipe_vld_q[k] <= pipe_vld_q[k-1];
        acc_off_q[k]  <= acc_off_q[k-1];
        inp_off_q[k]  <= inp_off_q[k-1];
        wgt_off_q[k]  <= wgt_off_q[k-1];
      end
      idx_vld_q <= pipe_vld_q[UOP_LAT-1];
      if (pipe_vld_q[UOP_LAT-1]) begin
        acc_rd_idx <= ACC_IDX_WIDTH'(uop_data[10:0]) + acc_off_q[UOP_LAT-1];
        inp_idx    <= INP_IDX_WIDTH'(uop_data[21:11]) + inp_off_q[UOP_LAT-1];
        wgt_idx    <= WGT_IDX_WIDTH'(uop_data[31:22]) + wgt_off_q[UOP_LAT-1];
      end
      wb_vld_q[0] <= idx_vld_q;
      wb_idx_q[0] <= acc_rd_idx;
      for (int k = 1; k < int'(WB_LAT); k++) begin
        wb_vld_q[k] <= wb_vld_q[k-1];
        wb_idx_q[k] <= wb_idx_q[k-1];
      end
    end
  end

endmodule

// File: tb/tb_gemm_loop_ctrl.sv
// Directed bench for gemm_loop_ctrl: a model of the loop nest pushes expected
// beats into queues at issue time, a negedge monitor pops and compares them.
module tb_gemm_loop_ctrl;

  logic         clk = 1'b0;
  logic         rst, insn_valid, insn_ready, stall;
  logic [127:0] insn;
  logic [12:0]  upc;
  logic [31:0]  uop_data;
  logic         idx_valid, reset_mode, acc_wr_en, done;
  logic [10:0]  acc_rd_idx, inp_idx, acc_wr_idx;
  logic [9:0]   wgt_idx;

  gemm_loop_ctrl dut (
    .clk(clk), .rst(rst), .insn(insn), .insn_valid(insn_valid), .insn_ready(insn_ready),
    .stall(stall), .upc(upc), .uop_data(uop_data), .idx_valid(idx_valid),
    .acc_rd_idx(acc_rd_idx), .inp_idx(inp_idx), .wgt_idx(wgt_idx), .reset_mode(reset_mode),
    .acc_wr_en(acc_wr_en), .acc_wr_idx(acc_wr_idx), .done(done)
  );

  always #5 clk = ~clk;

  // Micro-op store with one cycle of read latency, held while stalled
  logic [31:0] mem [64];
  always @(posedge clk) if (!stall) uop_data <= mem[upc[5:0]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int bgn, en, io, ii, dout, din, sout, sin, wout, win;
    bit rr;
  } prog_t;

  logic [32:0] idx_q [$];
  logic [10:0] wb_q [$];
  int checks = 0, errors = 0;
  int acc_cyc = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mk(prog_t p);
    logic [127:0] v;
    v = '0;
    v[127] = 1'b1;  v[6:0] = 7'h55;  v[7] = p.rr;
    v[20:8] = 13'(p.bgn);  v[34:21] = 14'(p.en);
    v[48:35] = 14'(p.io);  v[62:49] = 14'(p.ii);
    v[73:63] = 11'(p.dout);  v[84:74] = 11'(p.din);
    v[95:85] = 11'(p.sout);  v[106:96] = 11'(p.sin);
    v[116:107] = 10'(p.wout);  v[126:117] = 10'(p.win);
    return v;
  endfunction

  // Reference loop nest using plain multiplication
  task automatic push(prog_t p);
    logic [10:0] a, n;
    logic [9:0]  w;
    for (int i = 0; i < p.io; i++)
      for (int j = 0; j < p.ii; j++)
        for (int u = p.bgn; u < p.en; u++) begin
          a = 11'(int'(mem[u][10:0]) + i * p.dout + j * p.din);
          n = 11'(int'(mem[u][21:11]) + i * p.sout + j * p.sin);
          w = 10'(int'(mem[u][31:22]) + i * p.wout + j * p.win);
          idx_q.push_back({p.rr, a, n, w});
          wb_q.push_back(a);
        end
  endtask

  task automatic send(prog_t p);
    @(negedge clk);
    chk("ready_before_send", insn_ready, 1);
    insn = mk(p);
    insn_valid = 1'b1;
    push(p);
    @(posedge clk);
    #1;
    insn_valid = 1'b0;
    insn = '1;
    acc_cyc = cyc;
  endtask

  task automatic wait_done(output int k);
    k = -1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        k = cyc - acc_cyc;
        break;
      end
    end
    checks++;
    assert (k >= 0) else begin
      errors++;
      $error("FAIL done_timeout: got no done expected done within 300 cycles");
    end
  endtask

  task automatic chk_empty();
    chk("idx_left", idx_q.size(), 0);
    chk("wb_left", wb_q.size(), 0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [32:0] e;
    logic [10:0] w;
    if (stall) begin
      checks++;
      assert ({idx_valid, acc_wr_en} === 2'b00) else begin
        errors++;
        $error("FAIL stall_quiet: got %b expected 00", {idx_valid, acc_wr_en});
      end
    end
    if (idx_valid === 1'b1) begin
      checks++;
      assert (idx_q.size() > 0) else begin
        errors++;
        $error("FAIL idx_extra: got beat %0h expected none", {acc_rd_idx, inp_idx, wgt_idx});
      end
      if (idx_q.size() > 0) begin
        e = idx_q.pop_front();
        checks++;
        assert ({reset_mode, acc_rd_idx, inp_idx, wgt_idx} === e) else begin
          errors++;
          $error("FAIL idx_beat: got %0h expected %0h",
                 {reset_mode, acc_rd_idx, inp_idx, wgt_idx}, e);
        end
      end
    end
    if (acc_wr_en === 1'b1) begin
      checks++;
      assert (wb_q.size() > 0) else begin
        errors++;
        $error("FAIL wb_extra: got write %0h expected none", acc_wr_idx);
      end
      if (wb_q.size() > 0) begin
        w = wb_q.pop_front();
        checks++;
        assert (acc_wr_idx === w) else begin
          errors++;
          $error("FAIL wb_idx: got %0h expected %0h", acc_wr_idx, w);
        end
      end
    end
  end

  initial begin
    prog_t p_one, p_main, p_main_rr, p_noin, p_rev, p_wrap;
    logic [2:0] ev [7];
    int k;

    rst = 1'b1;  stall = 1'b0;  insn_valid = 1'b0;  insn = '0;  uop_data = '0;
    for (int u = 0; u < 64; u++) mem[u] = {10'(u * 7 + 3), 11'(u * 13 + 100), 11'(u * 5 + 1)};
    mem[0] = '0;
    mem[4] = {10'd9, 11'd17, 11'd2040};

    p_one     = '{bgn: 0, en: 1, io: 1, ii: 1, dout: 0, din: 0, sout: 0, sin: 0, wout: 0, win: 0, rr: 0};
    p_main    = '{bgn: 2, en: 4, io: 2, ii: 3, dout: 8, din: 1, sout: 4, sin: 1, wout: 2, win: 1, rr: 0};
    p_main_rr = p_main;
    p_main_rr.rr = 1;
    p_noin    = '{bgn: 0, en: 2, io: 1, ii: 0, dout: 1, din: 1, sout: 1, sin: 1, wout: 1, win: 1, rr: 0};
    p_rev     = '{bgn: 5, en: 5, io: 1, ii: 1, dout: 1, din: 1, sout: 1, sin: 1, wout: 1, win: 1, rr: 1};
    p_wrap    = '{bgn: 4, en: 5, io: 1, ii: 2, dout: 0, din: 16, sout: 0, sin: 2000, wout: 0, win: 1000, rr: 0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", insn_ready, 1);
    chk("rst_upc", upc, 0);
    chk("rst_idx_valid", idx_valid, 0);
    chk("rst_acc_wr_en", acc_wr_en, 0);
    chk("rst_done", done, 0);
    chk("rst_acc_rd_idx", acc_rd_idx, 0);
    chk("rst_inp_idx", inp_idx, 0);
    chk("rst_wgt_idx", wgt_idx, 0);
    chk("rst_acc_wr_idx", acc_wr_idx, 0);
    chk("rst_reset_mode", reset_mode, 0);

    // Single micro-op: idx_valid at t+2, write-back at t+4, done at t+5
    ev = '{3'b000, 3'b000, 3'b100, 3'b000, 3'b010, 3'b001, 3'b000};
    send(p_one);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      chk($sformatf("single_cycle%0d", c), {idx_valid, acc_wr_en, done}, ev[c]);
    end
    chk("single_ready_after", insn_ready, 1);
    chk_empty();

    // Two-level loop, 12 beats, done at t+N+4
    send(p_main_rr);
    wait_done(k);
    chk("main_done_cycle", k, 16);
    chk("main_upc_hold", upc, 3);
    chk("main_reset_mode", reset_mode, 1);
    chk_empty();

    // Same program with a 3-cycle stall mid-issue
    send(p_main);
    repeat (4) @(posedge clk);
    #1 stall = 1'b1;
    repeat (3) @(posedge clk);
    #1 stall = 1'b0;
    wait_done(k);
    chk("stall_done_cycle", k, 19);
    chk_empty();

    // Empty programs go straight to done
    send(p_noin);
    @(negedge clk);
    chk("noin_done", done, 1);
    @(negedge clk);
    chk("noin_ready", insn_ready, 1);
    chk("noin_done_clear", done, 0);
    send(p_rev);
    @(negedge clk);
    chk("rev_done", done, 1);
    chk_empty();

    // Index wrap modulo field width
    send(p_wrap);
    wait_done(k);
    chk("wrap_done_cycle", k, 6);
    chk_empty();

    // Reset mid-issue, then a clean rerun
    send(p_main_rr);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    idx_q.delete();
    wb_q.delete();
    @(negedge clk);
    chk("midrst_idx_valid", idx_valid, 0);
    chk("midrst_acc_wr_en", acc_wr_en, 0);
    chk("midrst_ready", insn_ready, 1);
    chk("midrst_reset_mode", reset_mode, 0);
    send(p_main);
    wait_done(k);
    chk("rerun_done_cycle", k, 16);
    chk_empty();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
